// File: rtl/decode_pkg.sv
// decode_pkg: shared definitions for the RV32I decode stage.
//   - datapath sizing (XLEN, NREGS, REG_AW)
//   - supported opcodes, ALUControl and ResultSrc encodings
//   - ImmSrc enum and the control-word struct produced by the decoder
//   - alu_decode helper mapping funct3/sub-select to an ALUControl code
package decode_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned NREGS  = 32;
   localparam int unsigned REG_AW = 5;

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_IALU = 7'b0010011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_PC4 = 2'b10;

   typedef enum logic [1:0] {
      IMM_I = 2'b00,
      IMM_S = 2'b01,
      IMM_B = 2'b10,
      IMM_J = 2'b11
   } imm_src_t;

   typedef struct packed {
      logic       reg_write;
      logic [1:0] result_src;
      logic       mem_write;
      logic       jump;
      logic       branch;
      logic       alu_src;
      logic [2:0] alu_control;
      imm_src_t   imm_src;
   } ctrl_t;

   // funct3 values outside add/slt/or/and (shifts, sltu, xor) have no ALU
   // code in this datapath and fall back to add.
   function automatic logic [2:0] alu_decode(input logic [2:0] funct3,
                                             input logic       sub);
      logic [2:0] code;
      case (funct3)
         3'b000:  code = sub ? ALU_SUB : ALU_ADD;
         3'b010:  code = ALU_SLT;
         3'b110:  code = ALU_OR;
         3'b111:  code = ALU_AND;
         default: code = ALU_ADD;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/decode_cycle_reg_file.sv
// reg_file: 32x32 architectural register file, 2 combinational read ports,
// 1 synchronous write port, asynchronous active-low clear.
//   clk, rst            clock / async active-low clear of all registers
//   addr1, addr2        read indices; data1, data2 read data
//   write_en, addr_w,   write port (rising edge); writes to x0 ignored
//   write_data
// A read of the register being written in the same cycle returns write_data
// (write-through), so decode sees the writeback value without a bypass.
module reg_file
   import decode_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] addr1,
   input  logic [REG_AW-1:0] addr2,
   input  logic              write_en,
   input  logic [REG_AW-1:0] addr_w,
   input  logic [XLEN-1:0]   write_data,
   output logic [XLEN-1:0]   data1,
   output logic [XLEN-1:0]   data2
);

   logic [XLEN-1:0] regs [NREGS];
   logic            write_live;

   assign write_live = write_en && (addr_w != '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (write_live) begin
         regs[addr_w] <= write_data;
      end
   end

   always_comb begin
      if (addr1 == '0)                          data1 = '0;
      else if (write_live && addr_w == addr1)   data1 = write_data;
      else                                      data1 = regs[addr1];
   end

   always_comb begin
      if (addr2 == '0)                          data2 = '0;
      else if (write_live && addr_w == addr2)   data2 = write_data;
      else                                      data2 = regs[addr2];
   end

endmodule

// File: rtl/decode_cycle.sv
// decode_cycle: RV32I decode stage. Decodes InstrD, reads the register file,
// extends the immediate and registers everything into the ID/EX stage.
//   clk, rst                     clock / async active-low reset
//   InstrD, PCD, PCPlus4D        from the IF/ID register
//   RegWriteW, RDW, ResultW      writeback port into the register file
//   FlushE                       synchronous bubble into ID/EX
//   Rs1D, Rs2D                   combinational source indices (hazard unit)
//   *E outputs                   ID/EX register contents
// Optional feature macro DECODE_ILLEGAL_EN: adds registered IllegalE and
// forces all controls to 0 for unsupported opcodes / bad R-type funct7.
module decode_cycle
   import decode_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [XLEN-1:0]   InstrD,
   input  logic [XLEN-1:0]   PCD,
   input  logic [XLEN-1:0]   PCPlus4D,
   input  logic              RegWriteW,
   input  logic [REG_AW-1:0] RDW,
   input  logic [XLEN-1:0]   ResultW,
   input  logic              FlushE,
   output logic [REG_AW-1:0] Rs1D,
   output logic [REG_AW-1:0] Rs2D,
   output logic              RegWriteE,
   output logic [1:0]        ResultSrcE,
   output logic              MemWriteE,
   output logic              JumpE,
   output logic              BranchE,
   output logic              ALUSrcE,
   output logic [2:0]        ALUControlE,
   output logic [XLEN-1:0]   RD1E,
   output logic [XLEN-1:0]   RD2E,
   output logic [XLEN-1:0]   ImmExtE,
   output logic [REG_AW-1:0] Rs1E,
   output logic [REG_AW-1:0] Rs2E,
   output logic [REG_AW-1:0] RdE,
`ifdef DECODE_ILLEGAL_EN
   output logic              IllegalE,
`endif
   output logic [XLEN-1:0]   PCE,
   output logic [XLEN-1:0]   PCPlus4E
);

   logic [6:0]        opcode;
   logic [2:0]        funct3;
   logic [6:0]        funct7;
   logic [REG_AW-1:0] rd;
   ctrl_t             ctrl;
   logic [XLEN-1:0]   imm_ext;
   logic [XLEN-1:0]   rd1;
   logic [XLEN-1:0]   rd2;
`ifdef DECODE_ILLEGAL_EN
   logic              illegal;
`endif

   assign opcode = InstrD[6:0];
   assign funct3 = InstrD[14:12];
   assign funct7 = InstrD[31:25];
   assign rd     = InstrD[11:7];
   assign Rs1D   = InstrD[19:15];
   assign Rs2D   = InstrD[24:20];

   reg_file u_reg_file (
      .clk        (clk),
      .rst        (rst),
      .addr1      (Rs1D),
      .addr2      (Rs2D),
      .write_en   (RegWriteW),
      .addr_w     (RDW),
      .write_data (ResultW),
      .data1      (rd1),
      .data2      (rd2)
   );

   // Main + ALU decoder. Unsupported opcodes leave the all-zero control word.
   always_comb begin
      ctrl = '0;
`ifdef DECODE_ILLEGAL_EN
      illegal = 1'b0;
`endif
      case (opcode)
         OP_LW: begin
            ctrl.reg_write  = 1'b1;
            ctrl.result_src = RES_MEM;
            ctrl.alu_src    = 1'b1;
            ctrl.imm_src    = IMM_I;
         end
         OP_SW: begin
            ctrl.mem_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            ctrl.imm_src   = IMM_S;
         end
         OP_R: begin
            ctrl.reg_write   = 1'b1;
            ctrl.alu_control = alu_decode(funct3, funct7[5]);
`ifdef DECODE_ILLEGAL_EN
            illegal = (funct7 != F7_BASE) && (funct7 != F7_ALT);
`endif
         end
         OP_IALU: begin
            ctrl.reg_write   = 1'b1;
            ctrl.alu_src     = 1'b1;
            ctrl.imm_src     = IMM_I;
            ctrl.alu_control = alu_decode(funct3, 1'b0);
         end
         OP_BEQ: begin
            ctrl.branch      = 1'b1;
            ctrl.imm_src     = IMM_B;
            ctrl.alu_control = ALU_SUB;
         end
         OP_JAL: begin
            ctrl.reg_write  = 1'b1;
            ctrl.result_src = RES_PC4;
            ctrl.jump       = 1'b1;
            ctrl.imm_src    = IMM_J;
         end
         default: begin
`ifdef DECODE_ILLEGAL_EN
            illegal = 1'b1;
`else
            ctrl = '0;
`endif
         end
      endcase
`ifdef DECODE_ILLEGAL_EN
      if (illegal) ctrl = '0;
`endif
   end

   // Immediate extender; B/J offsets are halfword-aligned so bit 0 is 0.
   always_comb begin
      case (ctrl.imm_src)
         IMM_S:   imm_ext = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
         IMM_B:   imm_ext = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25],
                             InstrD[11:8], 1'b0};
         IMM_J:   imm_ext = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20],
                             InstrD[30:21], 1'b0};
         default: imm_ext = {{20{InstrD[31]}}, InstrD[31:20]};
      endcase
   end

   // ID/EX register: flush inserts an all-zero bubble.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst || FlushE) begin
         RegWriteE   <= 1'b0;
         ResultSrcE  <= '0;
         MemWriteE   <= 1'b0;
         JumpE       <= 1'b0;
         BranchE     <= 1'b0;
         ALUSrcE     <= 1'b0;
         ALUControlE <= '0;
         RD1E        <= '0;
         RD2E        <= '0;
         ImmExtE     <= '0;
         Rs1E        <= '0;
         Rs2E        <= '0;
         RdE         <= '0;
         PCE         <= '0;
         PCPlus4E    <= '0;
      end else begin
         RegWriteE   <= ctrl.reg_write;
         ResultSrcE  <= ctrl.result_src;
         MemWriteE   <= ctrl.mem_write;
         JumpE       <= ctrl.jump;
         BranchE     <= ctrl.branch;
         ALUSrcE     <= ctrl.alu_src;
         ALUControlE <= ctrl.alu_control;
         RD1E        <= rd1;
         RD2E        <= rd2;
         ImmExtE     <= imm_ext;
         Rs1E        <= Rs1D;
         Rs2E        <= Rs2D;
         RdE         <= rd;
         PCE         <= PCD;
         PCPlus4E    <= PCPlus4D;
      end
   end

`ifdef DECODE_ILLEGAL_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst || FlushE) IllegalE <= 1'b0;
      else                IllegalE <= illegal;
   end
`endif

endmodule

// File: tb/tb_decode_cycle.sv
module tb_decode_cycle;

   typedef struct packed {
      logic        regw;
      logic [1:0]  rsrc;
      logic        memw;
      logic        jump;
      logic        branch;
      logic        alusrc;
      logic [2:0]  aluc;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] pc;
      logic [31:0] pc4;
      logic        ill;
   } eout_t;

   logic        clk, rst;
   logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
   logic        RegWriteW, FlushE;
   logic [4:0]  RDW;
   logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE;
   logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
   logic [1:0]  ResultSrcE;
   logic [2:0]  ALUControlE;
   logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
`ifdef DECODE_ILLEGAL_EN
   logic        IllegalE;
`endif

   int checks = 0;
   int errors = 0;
   logic [31:0] mregs [32];
   eout_t obs, exp;

   decode_cycle dut (
      .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
      .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .FlushE(FlushE),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE),
      .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE),
      .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
      .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
`ifdef DECODE_ILLEGAL_EN
      .IllegalE(IllegalE),
`endif
      .PCE(PCE), .PCPlus4E(PCPlus4E)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always_comb begin
      obs.regw   = RegWriteE;
      obs.rsrc   = ResultSrcE;
      obs.memw   = MemWriteE;
      obs.jump   = JumpE;
      obs.branch = BranchE;
      obs.alusrc = ALUSrcE;
      obs.aluc   = ALUControlE;
      obs.rd1    = RD1E;
      obs.rd2    = RD2E;
      obs.imm    = ImmExtE;
      obs.rs1    = Rs1E;
      obs.rs2    = Rs2E;
      obs.rd     = RdE;
      obs.pc     = PCE;
      obs.pc4    = PCPlus4E;
`ifdef DECODE_ILLEGAL_EN
      obs.ill    = IllegalE;
`else
      obs.ill    = 1'b0;
`endif
   end

   task automatic check(input string tag, input logic [255:0] o, input logic [255:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   // ALU code from the instruction-set meaning of funct3.
   function automatic logic [2:0] alu_ref(input logic [2:0] f3, input logic sub);
      case (f3)
         3'd0:    return sub ? 3'b001 : 3'b000;  // add / sub
         3'd2:    return 3'b101;                 // slt
         3'd6:    return 3'b011;                 // or
         3'd7:    return 3'b010;                 // and
         default: return 3'b000;
      endcase
   endfunction

   function automatic logic [31:0] ref_read(input logic [4:0] a, input logic we,
                                            input logic [4:0] wa, input logic [31:0] wd);
      if (a == 5'd0) return 32'd0;
      if (we && wa == a) return wd;
      return mregs[a];
   endfunction

   function automatic eout_t model(input logic [31:0] i, input logic [31:0] r1,
                                   input logic [31:0] r2, input logic [31:0] pc,
                                   input logic [31:0] pc4);
      eout_t e;
      logic  legal;
      logic [6:0] f7;
      e = '0;
      f7 = i[31:25];
      e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.rd = i[11:7];
      e.rd1 = r1; e.rd2 = r2; e.pc = pc; e.pc4 = pc4;
      e.imm = $signed(i) >>> 20;
      legal = 1'b1;
      case (i[6:0])
         7'h03: begin e.regw = 1; e.rsrc = 2'd1; e.alusrc = 1; end
         7'h23: begin e.memw = 1; e.alusrc = 1; e.imm = {e.imm[31:5], i[11:7]}; end
         7'h33: begin
            e.regw = 1; e.aluc = alu_ref(i[14:12], f7[5]);
            legal = (f7 == 7'h00) || (f7 == 7'h20);
         end
         7'h13: begin e.regw = 1; e.alusrc = 1; e.aluc = alu_ref(i[14:12], 1'b0); end
         7'h63: begin
            e.branch = 1; e.aluc = 3'b001;
            e.imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
         end
         7'h6F: begin
            e.regw = 1; e.rsrc = 2'd2; e.jump = 1;
            e.imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
         end
         default: legal = 1'b0;
      endcase
`ifdef DECODE_ILLEGAL_EN
      if (!legal) begin
         e.regw = 0; e.rsrc = 0; e.memw = 0; e.jump = 0;
         e.branch = 0; e.alusrc = 0; e.aluc = 0; e.ill = 1;
      end
`else
      if (!legal) e.ill = 1'b0;
`endif
      return e;
   endfunction

   // Drive one instruction, predict ID/EX contents, clock once, settle 1.
   task automatic step(input logic [31:0] instr, input logic rw, input logic [4:0] rdw,
                       input logic [31:0] res, input logic flush, output eout_t e);
      logic [31:0] pc;
      pc = $urandom & 32'hFFFF_FFFC;
      InstrD = instr; PCD = pc; PCPlus4D = pc + 32'd4;
      RegWriteW = rw; RDW = rdw; ResultW = res; FlushE = flush;
      if (flush) e = '0;
      else e = model(instr, ref_read(instr[19:15], rw, rdw, res),
                     ref_read(instr[24:20], rw, rdw, res), pc, pc + 32'd4);
      @(posedge clk);
      if (rw && rdw != 5'd0) mregs[rdw] = res;
      #1;
   endtask

   initial begin
      logic [31:0] ins;
      logic [6:0]  op;
      logic        rw, fl;
      logic [4:0]  rdw;
      logic [31:0] res;
      logic [6:0]  ops [12];
      ops = '{7'h03, 7'h23, 7'h33, 7'h33, 7'h13, 7'h13, 7'h63, 7'h6F,
              7'h7F, 7'h37, 7'h67, 7'h00};
      for (int k = 0; k < 32; k++) mregs[k] = '0;
      rst = 1'b0; InstrD = '0; PCD = '0; PCPlus4D = '0;
      RegWriteW = 1'b0; RDW = '0; ResultW = '0; FlushE = 1'b0;
      #1;
      check("reset_initial", obs, '0);
      #1 rst = 1'b1;

      // addi x5,x0,-3
      step(32'hFFD00293, 0, 0, 0, 0, exp);
      check("addi_imm", ImmExtE, 32'hFFFF_FFFD);
      check("addi_alusrc", ALUSrcE, 1'b1);
      check("addi_aluc", ALUControlE, 3'b000);
      check("addi_regw", RegWriteE, 1'b1);
      check("addi_rd", RdE, 5'd5);
      check("addi_all", obs, exp);

      // write x5 while decoding a nop
      step(32'h00000013, 1, 5'd5, 32'h0000_A5A5, 0, exp);
      check("nop_wb", obs, exp);

      // write-through: add x7,x6,x6 with x6 written this cycle
      step(32'h006303B3, 1, 5'd6, 32'h0000_1234, 0, exp);
      check("wt_rd1", RD1E, 32'h0000_1234);
      check("wt_rd2", RD2E, 32'h0000_1234);
      check("wt_all", obs, exp);

      // x0 write ignored, including same-cycle read of x0
      step(32'h000000B3, 1, 5'd0, 32'hFFFF_FFFF, 0, exp);
      check("x0_same_cycle", RD1E, 32'd0);
      step(32'h000000B3, 0, 5'd0, 32'd0, 0, exp);
      check("x0_after", RD1E, 32'd0);

      // beq x1,x2,-8 then the same with flush
      step(32'hFE208CE3, 0, 0, 0, 0, exp);
      check("beq_branch", BranchE, 1'b1);
      check("beq_aluc", ALUControlE, 3'b001);
      check("beq_imm", ImmExtE, 32'hFFFF_FFF8);
      check("beq_all", obs, exp);
      step(32'hFE208CE3, 0, 0, 0, 1, exp);
      check("beq_flush", obs, '0);

      // flush and writeback together: flush wins, write commits
      step(32'h006303B3, 1, 5'd9, 32'h0000_0077, 1, exp);
      check("flush_wb", obs, '0);
      step(32'h00048093, 0, 0, 0, 0, exp);  // addi x1,x9,0
      check("flush_wb_commit", RD1E, 32'h0000_0077);

      // unsupported opcode
      step(32'h1234507F, 0, 0, 0, 0, exp);
      check("illegal_ctrl", {RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE,
                              ALUSrcE, ALUControlE}, 10'd0);
`ifdef DECODE_ILLEGAL_EN
      check("illegal_flag", IllegalE, 1'b1);
`endif
      check("illegal_all", obs, exp);

      // mid-run reset, then x5 must read 0
      step(32'h00028093, 0, 0, 0, 0, exp);  // addi x1,x5,0
      check("x5_before_reset", RD1E, 32'h0000_A5A5);
      #2 rst = 1'b0;
      #1 check("reset_mid", obs, '0);
      for (int k = 0; k < 32; k++) mregs[k] = '0;
      #1 rst = 1'b1;
      step(32'h00028093, 0, 0, 0, 0, exp);
      check("x5_after_reset", RD1E, 32'd0);

      // randomized instruction stream against the model
      for (int n = 0; n < 300; n++) begin
         op  = ops[$urandom_range(0, 11)];
         ins = $urandom;
         ins[6:0] = op;
         if (op == 7'h33) begin
            case ($urandom_range(0, 3))
               0, 1:    ins[31:25] = 7'h00;
               2:       ins[31:25] = 7'h20;
               default: ins[31:25] = 7'($urandom);
            endcase
         end
         rw  = ($urandom_range(0, 1) == 1);
         rdw = 5'($urandom);
         if ($urandom_range(0, 3) == 0) rdw = ins[19:15];
         res = $urandom;
         fl  = ($urandom_range(0, 7) == 0);
         InstrD = ins;
         #0 check("rand_rsD", {Rs1D, Rs2D}, {ins[19:15], ins[24:20]});
         step(ins, rw, rdw, res, fl, exp);
         check("rand_all", obs, exp);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
